// File: rtl/fluid_pixel_pipeline.sv
// Raster position -> lattice-cell BRAM read -> RGB colouring; colour and coordinates leave together after LAT cycles.
// No backpressure: accepts one pixel every cycle and never stalls.
module fluid_pixel_pipeline #(
    parameter int GRID_W       = 205,
    parameter int GRID_H       = 155,
    parameter int CELL_SHIFT   = 2,
    parameter int DIRS         = 9,
    parameter int BARRIER_DIR  = 5,
    parameter int BRAM_LATENCY = 2,
    localparam int ADDR_W      = $clog2(GRID_W * GRID_H),
    localparam int SUM_W       = 8 + $clog2(DIRS),
    localparam int LAT         = BRAM_LATENCY + 3
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic [1:0]          mode_in,
    input  logic                test_button,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    input  logic [DIRS*8-1:0]   data_in,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic                pixel_valid_out,
    output logic [7:0]          red_out,
    output logic [7:0]          green_out,
    output logic [7:0]          blue_out
);

    logic [10:0]       x;
    logic [9:0]        y;
    logic              in_bounds;
    logic [ADDR_W-1:0] addr_calc;

    always_comb begin
        x         = hcount_in >> CELL_SHIFT;
        y         = vcount_in >> CELL_SHIFT;
        in_bounds = (x < 11'(GRID_W)) && (y < 10'(GRID_H));
        addr_calc = ADDR_W'(x) + ADDR_W'(GRID_W) * ADDR_W'(y);
    end

    // Flags are consumed at Stage C, one stage before the coordinates leave.
    logic [10:0]      h_dly [LAT];
    logic [9:0]       v_dly [LAT];
    logic [LAT-2:0]   inb_dly;
    logic [LAT-2:0]   tst_dly;
    logic [LAT-1:0]   vld_dly;

    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] sum_q;
    logic             barrier_c;
    logic             barrier_q;
    logic [1:0]       mode_q;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < DIRS; i++) begin
            sum_c = sum_c + SUM_W'(data_in[8*i +: 8]);
        end
        barrier_c = (data_in[8*BARRIER_DIR +: 8] == 8'hFF);
    end

    logic [11:0] s12;
    logic [7:0]  top8;
    logic        inb_c;
    logic        tst_c;
    logic [23:0] rgb_c;

    always_comb begin
        s12   = 12'(sum_q);
        top8  = sum_q[SUM_W-1 -: 8];
        inb_c = inb_dly[LAT-2];
        tst_c = tst_dly[LAT-2];
        rgb_c = 24'h000000;
        if (!inb_c) begin
            rgb_c = 24'h000000;
        end else if (barrier_q) begin
            rgb_c = (mode_q == 2'd3) ? 24'hFFFFFF : 24'h000000;
        end else if (mode_q == 2'd3) begin
            rgb_c = 24'h000000;
        end else if (tst_c) begin
            rgb_c = {8'd219, 8'd48, 8'd130};
        end else begin
            case (mode_q)
                2'd0:    rgb_c = {s12[11:8], 4'b0, s12[7:4], 4'b0, s12[3:0], 4'b0};
                2'd1:    rgb_c = {top8, top8, top8};
                2'd2:    rgb_c = {top8, 8'h00, ~top8};
                default: rgb_c = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            addr_out  <= '0;
            inb_dly   <= '0;
            tst_dly   <= '0;
            vld_dly   <= '0;
            sum_q     <= '0;
            barrier_q <= 1'b0;
            mode_q    <= 2'd0;
            red_out   <= 8'd0;
            green_out <= 8'd0;
            blue_out  <= 8'd0;
            for (int i = 0; i < LAT; i++) begin
                h_dly[i] <= '0;
                v_dly[i] <= '0;
            end
        end else begin
            addr_out  <= in_bounds ? addr_calc : '0;
            inb_dly   <= {inb_dly[LAT-3:0], in_bounds};
            tst_dly   <= {tst_dly[LAT-3:0], test_button};
            vld_dly   <= {vld_dly[LAT-2:0], 1'b1};
            h_dly[0]  <= hcount_in;
            v_dly[0]  <= vcount_in;
            for (int i = 1; i < LAT; i++) begin
                h_dly[i] <= h_dly[i-1];
                v_dly[i] <= v_dly[i-1];
            end
            sum_q     <= sum_c;
            barrier_q <= barrier_c;
            // Only the first pixel of a frame may change the colour mode.
            if (hcount_in == 11'd0 && vcount_in == 10'd0) begin
                mode_q <= mode_in;
            end
            red_out   <= rgb_c[23:16];
            green_out <= rgb_c[15:8];
            blue_out  <= rgb_c[7:0];
        end
    end

    assign hcount_out      = h_dly[LAT-1];
    assign vcount_out      = v_dly[LAT-1];
    assign pixel_valid_out = vld_dly[LAT-1];

endmodule

// File: doc/fluid_pixel_pipeline.md
# fluid_pixel_pipeline

Parametrised, pipelined pixel colouring stage between the fluid-state BRAM and the video output. It converts each raster position to a lattice-cell address and reads that cell's per-direction densities. It then produces RGB with run-time-selectable colour modes. Raster coordinates are delayed by the full pipeline latency, so colour and coordinates leave the block aligned.

## Interface
- GRID_W, 205, lattice columns
- GRID_H, 155, lattice rows
- CELL_SHIFT, 2, log2 of cell edge in pixels (cell = 2^CELL_SHIFT square)
- DIRS, 9, direction channels per cell, 8 bits each
- BARRIER_DIR, 5, channel whose value 8'hFF marks a barrier cell
- BRAM_LATENCY, 2, BRAM read latency in cycles, addr to data_in
- Derived: ADDR_W = $clog2(GRID_W*GRID_H); SUM_W = 8+$clog2(DIRS); LAT = BRAM_LATENCY+3
- pixel_clk_in  in  1  pixel clock, sole clock
- rst_in  in  1  synchronous, active-high reset
- mode_in  in  2  colour mode request
- test_button  in  1  pink override request
- hcount_in  in  11  raster x
- vcount_in  in  10  raster y
- data_in  in  DIRS×8  cell channels from BRAM, BRAM_LATENCY cycles after addr_out
- addr_out  out  ADDR_W  BRAM read address (registered)
- hcount_out  out  11  hcount_in delayed LAT cycles
- vcount_out  out  10  vcount_in delayed LAT cycles
- pixel_valid_out  out  1  outputs carry a real pixel
- red_out, green_out, blue_out  out  8 each  pixel colour (registered)

## Operation
- Stage A (cycle 0→1): x = hcount_in>>CELL_SHIFT, y = vcount_in>>CELL_SHIFT. in_bounds = (x < GRID_W) && (y < GRID_H). addr_out <= in_bounds ? x + GRID_W*y : 0. in_bounds, test_button, hcount_in and vcount_in enter a LAT-deep delay line.
- Stage B (data arrival +1): sum <= unsigned sum of all DIRS channels, SUM_W bits, never overflows. barrier <= (data_in[BARRIER_DIR] == 8'hFF).
- Stage C (+1): colour registered from sum, barrier, the delayed flags and the active mode.
  - Out of bounds: black, in every mode.
  - Barrier in modes 0–2: black. Barrier in mode 3: white (255,255,255).
  - Otherwise, with test flag set in modes 0–2: (219,48,130).
  - Mode 0 (banded): s12 = sum zero-extended/truncated to 12 bits; R={s12[11:8],4'b0}, G={s12[7:4],4'b0}, B={s12[3:0],4'b0}.
  - Mode 1 (grey): g = sum[SUM_W-1 -: 8]; R=G=B=g.
  - Mode 2 (heat): h = sum[SUM_W-1 -: 8]; R=h, G=0, B=255-h.
  - Mode 3 (barrier debug): non-barrier in-bounds cells are black; test flag ignored.
- Mode register: loads mode_in only in the cycle where hcount_in==0 && vcount_in==0. Otherwise it holds, so the mode never changes mid-frame. The value used for a pixel is the mode register at its Stage C; Stage C of pixel (0,0) uses the newly latched value.
- pixel_valid_out: a shift-register of ones, cleared by reset, filled one stage per cycle.

## Timing
- Latency hcount_in → RGB/hcount_out = LAT cycles (5 at default). Throughput is one pixel per cycle, with no stalls.
- addr_out is valid 1 cycle after hcount_in/vcount_in. data_in is sampled BRAM_LATENCY cycles later.
- Reset values: addr_out=0, RGB=0, hcount_out=0, vcount_out=0, pixel_valid_out=0, mode=0, all delay lines 0.
- pixel_valid_out rises exactly LAT cycles after the first non-reset cycle. Reset mid-frame zeroes all outputs the next cycle and restarts the fill.
- Boundaries:
  - x == GRID_W-1, y == GRID_H-1 is in bounds, giving addr GRID_W*GRID_H-1.
  - x == GRID_W or y == GRID_H is black with addr 0.
  - Counter wrap (hcount back to 0) needs no special handling.

## Test plan
- Reset held 3 cycles, then a raster ramp -> all outputs 0 until cycle 5 after release. pixel_valid_out then 1 and hcount_out equals hcount_in from 5 cycles earlier.
- hcount=12, vcount=8 with BRAM model returning all channels 8'd10 -> addr_out=3+205*2=413 next cycle. Mode 0 sum=90 (0x05A) gives RGB (0x00,0x50,0xA0) at cycle 5.
- hcount=820 (x=205) -> addr_out=0 and RGB black. hcount=819, vcount=619 -> addr_out=31774 and a normal colour.
- data_in[5]=8'hFF with test_button=1 -> black in mode 0. Same input in mode 3 -> white. Non-barrier with test_button=1 in mode 1 -> (219,48,130).
- mode_in switched 0→2 mid-frame -> colours unchanged until the (0,0) pixel. Then all channels at 8'd255 (sum 2295) give R=143, G=0, B=112.
- Reset asserted mid-line for 1 cycle -> next cycle RGB=0 and pixel_valid_out=0; it recovers after 5 cycles.
